lif_neuron_array: RTL and testbench

- Parametrised array of N leaky integrate-and-fire neurons; successor to the single 8-bit leaky_integrate_fire neuron.
- Adds channel count, width, runtime threshold, selectable post-spike reset mode, refractory period and an explicit spike output.
- All neurons update in parallel on a global time-step strobe.
- Sits between the synaptic current accumulator (drives current) and the spike router (consumes spike).

---
 rtl/lif_pkg.sv | 27 ++
 rtl/lif_neuron_core.sv | 125 ++++++++++++
 rtl/lif_neuron_array.sv | 71 +++++++
 tb/tb_lif_neuron_array.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// -----------------------------------------------------------------------------
// lif_pkg
// Shared definitions for the leaky integrate-and-fire neuron array:
//   - post-spike reset-mode constants (RESET_ZERO, RESET_SUB)
//   - per-channel refractory state encoding
//   - saturating unsigned add helper
// -----------------------------------------------------------------------------
package lif_pkg;

  localparam int RESET_ZERO = 0;
  localparam int RESET_SUB  = 1;

  localparam logic [0:0] ST_INTEGRATE = 1'b0;
  localparam logic [0:0] ST_REFRACT   = 1'b1;

  // Unsigned a + b clamped to 2^width - 1 (width <= 31).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          width);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << width) - 33'd1;
    return (sum > max_v) ? max_v[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// -----------------------------------------------------------------------------
// lif_neuron_core
// One leaky integrate-and-fire neuron: membrane potential, refractory counter
// and (with LIF_SPIKE_COUNT_EN defined) a saturating spike counter.
//
// Ports:
//   clk, reset_n       clock / asynchronous active-low reset
//   stop               freeze; overrides step_en
//   step_en            time-step strobe
//   current            input current for this channel
//   threshold          firing threshold, 0 disables firing
//   spike              one-cycle spike pulse (registered)
//   v_out              registered membrane potential
//   count_clr          synchronous counter clear   (LIF_SPIKE_COUNT_EN only)
//   spike_count        saturating spike counter    (LIF_SPIKE_COUNT_EN only)
// -----------------------------------------------------------------------------
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRACT_STEPS = 2,
  parameter int RESET_MODE    = RESET_ZERO
`ifdef LIF_SPIKE_COUNT_EN
  ,
  parameter int CNT_WIDTH     = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stop,
  input  logic                  step_en,
  input  logic [DATA_WIDTH-1:0] current,
  input  logic [DATA_WIDTH-1:0] threshold,
`ifdef LIF_SPIKE_COUNT_EN
  input  logic                  count_clr,
  output logic [CNT_WIDTH-1:0]  spike_count,
`endif
  output logic                  spike,
  output logic [DATA_WIDTH-1:0] v_out
);

  localparam int RCNT_W = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;

  logic [DATA_WIDTH-1:0] v_q, v_d;
  logic [0:0]            st_q, st_d;
  logic [RCNT_W-1:0]     rcnt_q, rcnt_d;
  logic                  spike_q, spike_d;

  logic                  step;
  logic [DATA_WIDTH-1:0] leaked;
  logic [DATA_WIDTH-1:0] sum;

  assign step   = step_en & ~stop;
  // v - (v >> k) never underflows, so only the add of current needs clamping.
  assign leaked = v_q - (v_q >> LEAK_SHIFT);
  assign sum    = DATA_WIDTH'(sat_add(32'(leaked), 32'(current), DATA_WIDTH));

  always_comb begin
    v_d     = v_q;
    st_d    = st_q;
    rcnt_d  = rcnt_q;
    spike_d = 1'b0;
    if (step) begin
      if (st_q == ST_REFRACT) begin
        // Membrane frozen; leave refractory on the step that consumes the last count.
        rcnt_d = rcnt_q - RCNT_W'(1);
        if (rcnt_q == RCNT_W'(1)) begin
          st_d = ST_INTEGRATE;
        end
      end else if ((threshold != '0) && (sum >= threshold)) begin
        spike_d = 1'b1;
        v_d     = (RESET_MODE == RESET_SUB) ? (sum - threshold) : '0;
        if (REFRACT_STEPS > 0) begin
          st_d   = ST_REFRACT;
          rcnt_d = RCNT_W'(REFRACT_STEPS);
        end
      end else begin
        v_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q     <= '0;
      st_q    <= ST_INTEGRATE;
      rcnt_q  <= '0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      st_q    <= st_d;
      rcnt_q  <= rcnt_d;
      spike_q <= spike_d;
    end
  end

  assign spike = spike_q;
  assign v_out = v_q;

`ifdef LIF_SPIKE_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Clear takes priority over a spike landing on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (spike_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign spike_count = cnt_q;
`endif

endmodule

// File: rtl/lif_neuron_array.sv
// -----------------------------------------------------------------------------
// lif_neuron_array
// N_NEURONS independent leaky integrate-and-fire neurons updated in parallel on
// a global time-step strobe. Optional per-channel spike counters are built when
// the macro LIF_SPIKE_COUNT_EN is defined.
//
// Ports:
//   clk, reset_n   clock / asynchronous active-low reset
//   stop           freeze; step_en ignored while high
//   step_en        one-cycle time-step strobe
//   current        per-channel currents, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   threshold      shared firing threshold, 0 disables firing
//   spike          per-channel one-cycle spike pulses
//   v_out          per-channel registered membrane potentials
//   count_clr      clear all spike counters     (LIF_SPIKE_COUNT_EN only)
//   spike_count    per-channel spike counters   (LIF_SPIKE_COUNT_EN only)
// -----------------------------------------------------------------------------
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS     = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRACT_STEPS = 2,
  parameter int RESET_MODE    = RESET_ZERO
`ifdef LIF_SPIKE_COUNT_EN
  ,
  parameter int CNT_WIDTH     = 16
`endif
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            stop,
  input  logic                            step_en,
  input  logic [N_NEURONS*DATA_WIDTH-1:0] current,
  input  logic [DATA_WIDTH-1:0]           threshold,
`ifdef LIF_SPIKE_COUNT_EN
  input  logic                            count_clr,
  output logic [N_NEURONS*CNT_WIDTH-1:0]  spike_count,
`endif
  output logic [N_NEURONS-1:0]            spike,
  output logic [N_NEURONS*DATA_WIDTH-1:0] v_out
);

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_ch
    lif_neuron_core #(
      .DATA_WIDTH    (DATA_WIDTH),
      .LEAK_SHIFT    (LEAK_SHIFT),
      .REFRACT_STEPS (REFRACT_STEPS),
      .RESET_MODE    (RESET_MODE)
`ifdef LIF_SPIKE_COUNT_EN
      ,
      .CNT_WIDTH     (CNT_WIDTH)
`endif
    ) u_core (
      .clk         (clk),
      .reset_n     (reset_n),
      .stop        (stop),
      .step_en     (step_en),
      .current     (current[i*DATA_WIDTH +: DATA_WIDTH]),
      .threshold   (threshold),
`ifdef LIF_SPIKE_COUNT_EN
      .count_clr   (count_clr),
      .spike_count (spike_count[i*CNT_WIDTH +: CNT_WIDTH]),
`endif
      .spike       (spike[i]),
      .v_out       (v_out[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron_array
// Two instances share all inputs: dut0 resets the membrane to zero after a
// spike, dut1 subtracts the threshold. A reference model predicts every
// cycle's outputs into a queue; a monitor pops and compares after each edge.
// Spike counters are checked when LIF_SPIKE_COUNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_lif_neuron_array;

  logic        clk;
  logic        reset_n;
  logic        stop;
  logic        step_en;
  logic [31:0] current;
  logic [7:0]  threshold;
  logic [3:0]  spike0, spike1;
  logic [31:0] v0, v1;
`ifdef LIF_SPIKE_COUNT_EN
  logic        count_clr;
  logic [63:0] cnt0, cnt1;
`endif

  lif_neuron_array #(
    .N_NEURONS(4), .DATA_WIDTH(8), .LEAK_SHIFT(3), .REFRACT_STEPS(2), .RESET_MODE(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .stop(stop), .step_en(step_en),
    .current(current), .threshold(threshold),
`ifdef LIF_SPIKE_COUNT_EN
    .count_clr(count_clr), .spike_count(cnt0),
`endif
    .spike(spike0), .v_out(v0)
  );

  lif_neuron_array #(
    .N_NEURONS(4), .DATA_WIDTH(8), .LEAK_SHIFT(3), .REFRACT_STEPS(2), .RESET_MODE(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .stop(stop), .step_en(step_en),
    .current(current), .threshold(threshold),
`ifdef LIF_SPIKE_COUNT_EN
    .count_clr(count_clr), .spike_count(cnt1),
`endif
    .spike(spike1), .v_out(v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v0;
    logic [3:0]  s0;
    logic [31:0] v1;
    logic [3:0]  s1;
    logic [63:0] c0;
    logic [63:0] c1;
  } exp_t;

  exp_t q[$];
  int   npass  = 0;
  int   ntotal = 0;

  // Reference state: [mode][channel]
  int mv[2][4];
  int mr[2][4];
  int mc[2][4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int ch = 0; ch < 4; ch++) begin
        mv[m][ch] = 0;
        mr[m][ch] = 0;
        mc[m][ch] = 0;
      end
  endtask

  // Predicts outputs after the coming edge from the inputs now applied.
  task automatic model_step(input logic clr);
    exp_t e;
    int   sum;
    int   thr;
    bit   upd;
    bit   sp;
    e   = '{default: '0};
    upd = step_en && !stop;
    thr = int'(threshold);
    for (int m = 0; m < 2; m++) begin
      for (int ch = 0; ch < 4; ch++) begin
        sp = 1'b0;
        if (upd) begin
          if (mr[m][ch] > 0) begin
            mr[m][ch] = mr[m][ch] - 1;
          end else begin
            sum = mv[m][ch] - mv[m][ch] / 8 + int'(current[ch*8 +: 8]);
            if (sum > 255) sum = 255;
            if (thr != 0 && sum >= thr) begin
              sp        = 1'b1;
              mv[m][ch] = (m == 1) ? sum - thr : 0;
              mr[m][ch] = 2;
            end else begin
              mv[m][ch] = sum;
            end
          end
        end
        if (clr) mc[m][ch] = 0;
        else if (sp && mc[m][ch] < 65535) mc[m][ch] = mc[m][ch] + 1;
        if (m == 0) begin
          e.v0[ch*8 +: 8]   = 8'(mv[m][ch]);
          e.s0[ch]          = sp;
          e.c0[ch*16 +: 16] = 16'(mc[m][ch]);
        end else begin
          e.v1[ch*8 +: 8]   = 8'(mv[m][ch]);
          e.s1[ch]          = sp;
          e.c1[ch*16 +: 16] = 16'(mc[m][ch]);
        end
      end
    end
    q.push_back(e);
  endtask

  task automatic drive(input logic st, input logic se, input logic [31:0] cur,
                       input logic [7:0] thr, input logic clr);
    @(negedge clk);
    stop      = st;
    step_en   = se;
    current   = cur;
    threshold = thr;
`ifdef LIF_SPIKE_COUNT_EN
    count_clr = clr;
`endif
    model_step(clr);
  endtask

  // Monitor: outputs are valid every cycle; compare whenever a prediction is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("mon_v_mode0", 64'(v0), 64'(e.v0));
        check("mon_spike_mode0", 64'(spike0), 64'(e.s0));
        check("mon_v_mode1", 64'(v1), 64'(e.v1));
        check("mon_spike_mode1", 64'(spike1), 64'(e.s1));
`ifdef LIF_SPIKE_COUNT_EN
        check("mon_count_mode0", cnt0, e.c0);
        check("mon_count_mode1", cnt1, e.c1);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t2v[11];
    int t2s[11];
    logic [31:0] cur;
    logic [7:0]  thr;
    t2v = '{20, 38, 54, 68, 80, 90, 99, 0, 0, 0, 20};
    t2s = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    reset_n   = 1'b0;
    stop      = 1'b0;
    step_en   = 1'b0;
    current   = '0;
    threshold = 8'd100;
`ifdef LIF_SPIKE_COUNT_EN
    count_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_v", 64'({v1, v0}), 64'd0);
    check("reset_spike", 64'({spike1, spike0}), 64'd0);
`ifdef LIF_SPIKE_COUNT_EN
    check("reset_count", cnt0 | cnt1, 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // Single channel integrating a constant current through one spike and refractory.
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 1'b1, 32'd20, 8'd100, 1'b0);
      @(posedge clk);
      #2;
      check($sformatf("t2_v_step%0d", i + 1), 64'(v0[7:0]), 64'(t2v[i]));
      check($sformatf("t2_spike_step%0d", i + 1), 64'(spike0[0]), 64'(t2s[i]));
    end

    // Asynchronous reset between clock edges.
    drive(1'b0, 1'b1, 32'h1E1E1E1E, 8'd100, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_v", 64'({v1, v0}), 64'd0);
    check("async_reset_spike", 64'({spike1, spike0}), 64'd0);
    model_reset();
    step_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Subtract-threshold mode with a saturating sum.
    drive(1'b0, 1'b1, 32'd200, 8'd0, 1'b0);
    drive(1'b0, 1'b1, 32'd255, 8'd250, 1'b0);
    @(posedge clk);
    #2;
    check("sub_mode_v", 64'(v1[7:0]), 64'd5);
    check("sub_mode_spike", 64'(spike1[0]), 64'd1);
    check("zero_mode_v", 64'(v0[7:0]), 64'd0);
    drive(1'b0, 1'b0, 32'd0, 8'd250, 1'b0);
    @(posedge clk);
    #2;
    check("idle_spike_low", 64'({spike1, spike0}), 64'd0);

    // stop overrides step_en.
    repeat (3) drive(1'b0, 1'b1, 32'h32323232, 8'd100, 1'b0);
    repeat (5) drive(1'b1, 1'b1, 32'h32323232, 8'd100, 1'b0);
    @(posedge clk);
    #2;
    check("stop_spike_low", 64'({spike1, spike0}), 64'd0);

    // Firing disabled: membranes saturate.
    repeat (6) drive(1'b0, 1'b1, 32'hFFFFFFFF, 8'd0, 1'b0);
    @(posedge clk);
    #2;
    check("thr0_v_sat", 64'({v1, v0}), 64'hFFFFFFFF_FFFFFFFF);
    check("thr0_no_spike", 64'({spike1, spike0}), 64'd0);

`ifdef LIF_SPIKE_COUNT_EN
    drive(1'b0, 1'b0, 32'd0, 8'd100, 1'b1);
    repeat (9) drive(1'b0, 1'b1, 32'h00006400, 8'd100, 1'b0);
    @(posedge clk);
    #2;
    check("count_ch1_three", 64'(cnt0[31:16]), 64'd3);
    drive(1'b0, 1'b1, 32'h00006400, 8'd100, 1'b1);
    @(posedge clk);
    #2;
    check("clr_wins_spike", 64'(spike0[1]), 64'd1);
    check("clr_wins_count", 64'(cnt0[31:16]), 64'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cur = $urandom;
      thr = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), cur, thr,
            ($urandom_range(0, 15) == 0));
    end
    drive(1'b0, 1'b0, 32'd0, 8'd100, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
